// File: rtl/icb_rr_arb_pkg.sv
// Shared widths and helpers for the two-master ICB round-robin arbiter.
package icb_rr_arb_pkg;

    localparam int MemAddrBus   = 32;
    localparam int MemBus       = 32;
    localparam int OutsDepthDef = 4;

    function automatic int mask_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/icb_rr_arb_if.sv
// ICB command/response bundle; "master" issues commands, "slave" accepts them.
interface icb_rr_arb_if
    import icb_rr_arb_pkg::*;
#(
    parameter int AW = MemAddrBus,
    parameter int DW = MemBus
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_addr;
    logic              cmd_read;
    logic [DW-1:0]     cmd_wdata;
    logic [DW/8-1:0]   cmd_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [DW-1:0]     rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/icb_rr_arb_id_fifo.sv
// In-order ID FIFO: remembers which master issued each outstanding command.
module icb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/icb_rr_arb.sv
// Two-master to one-slave ICB arbiter: round-robin grant, stall lock,
// zero-latency command path and in-order response routing.
module icb_rr_arb
    import icb_rr_arb_pkg::*;
#(
    parameter int AW         = MemAddrBus,
    parameter int DW         = MemBus,
    parameter int OUTS_DEPTH = OutsDepthDef
) (
    input  logic          clk,
    input  logic          rst_n,
    icb_rr_arb_if.slave   m0,
    icb_rr_arb_if.slave   m1,
    icb_rr_arb_if.master  s,
    output logic          busy,
    output logic          rsp_orphan
);
    logic                  sel;
    logic                  lock;
    logic                  lock_id;
    logic                  rr_last;
    logic                  sel_valid;
    logic [AW-1:0]         sel_addr;
    logic                  sel_read;
    logic [DW-1:0]         sel_wdata;
    logic [mask_w(DW)-1:0] sel_wmask;
    logic                  cmd_hs;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_head;
    logic                  head_ready;
    logic                  rsp_pop;

    always_comb begin
        if (lock)
            sel = lock_id;
        else if (m0.cmd_valid ^ m1.cmd_valid)
            sel = m1.cmd_valid;
        else if (m0.cmd_valid)
            sel = ~rr_last;
        else
            sel = rr_last;
    end

    assign sel_valid = sel ? m1.cmd_valid : m0.cmd_valid;
    assign sel_addr  = sel ? m1.cmd_addr  : m0.cmd_addr;
    assign sel_read  = sel ? m1.cmd_read  : m0.cmd_read;
    assign sel_wdata = sel ? m1.cmd_wdata : m0.cmd_wdata;
    assign sel_wmask = sel ? m1.cmd_wmask : m0.cmd_wmask;

    assign s.cmd_valid = sel_valid & ~fifo_full;
    assign s.cmd_addr  = sel_addr;
    assign s.cmd_read  = sel_read;
    assign s.cmd_wdata = sel_wdata;
    assign s.cmd_wmask = sel_wmask;
    assign cmd_hs      = s.cmd_valid & s.cmd_ready;

    // Ready is qualified by the granted valid so idle masters never see it.
    assign m0.cmd_ready = ~sel & sel_valid & s.cmd_ready & ~fifo_full;
    assign m1.cmd_ready =  sel & sel_valid & s.cmd_ready & ~fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock       <= 1'b0;
            lock_id    <= 1'b0;
            rr_last    <= 1'b1;
            rsp_orphan <= 1'b0;
        end else begin
            if (cmd_hs) begin
                lock    <= 1'b0;
                rr_last <= sel;
            end else if (s.cmd_valid) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end
            if (s.rsp_valid & fifo_empty)
                rsp_orphan <= 1'b1;
        end
    end

    icb_id_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_hs),
        .din   (sel),
        .pop   (rsp_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // With nothing outstanding the response is swallowed rather than stalled.
    assign head_ready  = fifo_head ? m1.rsp_ready : m0.rsp_ready;
    assign s.rsp_ready = fifo_empty ? s.rsp_valid : head_ready;
    assign rsp_pop     = s.rsp_valid & s.rsp_ready & ~fifo_empty;

    assign m0.rsp_valid = s.rsp_valid & ~fifo_empty & ~fifo_head;
    assign m1.rsp_valid = s.rsp_valid & ~fifo_empty &  fifo_head;
    assign m0.rsp_err   = s.rsp_err;
    assign m1.rsp_err   = s.rsp_err;
    assign m0.rsp_rdata = s.rsp_rdata;
    assign m1.rsp_rdata = s.rsp_rdata;

    assign busy = lock | ~fifo_empty;

endmodule

// File: tb/tb_icb_rr_arb.sv
// Directed bench for icb_rr_arb: reset, pass-through, tie, lock, routing, full, orphan.
module tb_icb_rr_arb;
    logic clk;
    logic rst_n;
    logic busy;
    logic rsp_orphan;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    icb_rr_arb_if #(.AW(32), .DW(32)) m0_if ();
    icb_rr_arb_if #(.AW(32), .DW(32)) m1_if ();
    icb_rr_arb_if #(.AW(32), .DW(32)) s_if ();

    icb_rr_arb #(.AW(32), .DW(32), .OUTS_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if),
        .busy       (busy),
        .rsp_orphan (rsp_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_all();
        m0_if.cmd_valid = 0; m0_if.cmd_addr = 32'h100; m0_if.cmd_read = 0;
        m0_if.cmd_wdata = 0; m0_if.cmd_wmask = 4'hF;   m0_if.rsp_ready = 0;
        m1_if.cmd_valid = 0; m1_if.cmd_addr = 32'h200; m1_if.cmd_read = 0;
        m1_if.cmd_wdata = 0; m1_if.cmd_wmask = 4'hF;   m1_if.rsp_ready = 0;
        s_if.cmd_ready = 0;  s_if.rsp_valid = 0; s_if.rsp_err = 0; s_if.rsp_rdata = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_all();
        next_cyc();
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 0;
        idle_all();
        #2;
        got = {m0_if.cmd_ready, m1_if.cmd_ready, s_if.cmd_valid, s_if.rsp_ready,
               m0_if.rsp_valid, m1_if.rsp_valid, busy, rsp_orphan};
        total_cnt++;
        if (got !== 8'h00) $display("FAIL reset_outputs: got %b exp %b", got, 8'h00);
        else pass_cnt++;
        next_cyc();
        rst_n = 1;
        #2;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy);
        else pass_cnt++;
        next_cyc();
    endtask

    task automatic test_single();
        logic [3:0] got;
        idle_all();
        s_if.cmd_ready  = 1;
        m0_if.cmd_valid = 1;
        m0_if.cmd_addr  = 32'h2000_0010;
        m0_if.cmd_wdata = 32'hDEAD_BEEF;
        m0_if.cmd_wmask = 4'hF;
        #2;
        got = {s_if.cmd_valid, s_if.cmd_read, m0_if.cmd_ready, m1_if.cmd_ready};
        total_cnt++;
        if (got !== 4'b1010) $display("FAIL single_hs: got %b exp %b", got, 4'b1010);
        else pass_cnt++;
        total_cnt++;
        if (s_if.cmd_addr !== 32'h2000_0010) $display("FAIL single_addr: got %h exp %h", s_if.cmd_addr, 32'h2000_0010);
        else pass_cnt++;
        total_cnt++;
        if (s_if.cmd_wdata !== 32'hDEAD_BEEF) $display("FAIL single_wdata: got %h exp %h", s_if.cmd_wdata, 32'hDEAD_BEEF);
        else pass_cnt++;
        total_cnt++;
        if (s_if.cmd_wmask !== 4'hF) $display("FAIL single_wmask: got %h exp %h", s_if.cmd_wmask, 4'hF);
        else pass_cnt++;
        next_cyc();
        m0_if.cmd_valid = 0;
        s_if.rsp_valid  = 1;
        s_if.rsp_rdata  = 32'hCAFE_0001;
        m0_if.rsp_ready = 1;
        m1_if.rsp_ready = 1;
        #2;
        got = {m0_if.rsp_valid, m1_if.rsp_valid, s_if.rsp_ready, busy};
        total_cnt++;
        if (got !== 4'b1011) $display("FAIL single_rsp: got %b exp %b", got, 4'b1011);
        else pass_cnt++;
        total_cnt++;
        if (m0_if.rsp_rdata !== 32'hCAFE_0001) $display("FAIL single_rdata: got %h exp %h", m0_if.rsp_rdata, 32'hCAFE_0001);
        else pass_cnt++;
        next_cyc();
        s_if.rsp_valid = 0;
        #2;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b exp 0", busy);
        else pass_cnt++;
        next_cyc();
    endtask

    task automatic test_tie();
        logic [31:0] exp_addr;
        logic [1:0]  exp_rdy;
        logic [1:0]  got;
        idle_all();
        s_if.cmd_ready  = 1;
        m0_if.cmd_valid = 1;
        m1_if.cmd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
            exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
            #2;
            total_cnt++;
            if (s_if.cmd_addr !== exp_addr) $display("FAIL tie_addr[%0d]: got %h exp %h", i, s_if.cmd_addr, exp_addr);
            else pass_cnt++;
            got = {m0_if.cmd_ready, m1_if.cmd_ready};
            total_cnt++;
            if (got !== exp_rdy) $display("FAIL tie_ready[%0d]: got %b exp %b", i, got, exp_rdy);
            else pass_cnt++;
            next_cyc();
        end
        #2;
        total_cnt++;
        if (s_if.cmd_valid !== 1'b0) $display("FAIL tie_full_valid: got %b exp 0", s_if.cmd_valid);
        else pass_cnt++;
        m0_if.cmd_valid = 0;
        m1_if.cmd_valid = 0;
        s_if.rsp_valid  = 1;
        m0_if.rsp_ready = 1;
        m1_if.rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            s_if.rsp_rdata = 32'(i);
            #2;
            got = {m0_if.rsp_valid, m1_if.rsp_valid};
            total_cnt++;
            if (got !== exp_rdy) $display("FAIL tie_rsp_route[%0d]: got %b exp %b", i, got, exp_rdy);
            else pass_cnt++;
            next_cyc();
        end
        s_if.rsp_valid = 0;
        #2;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL tie_drain_busy: got %b exp 0", busy);
        else pass_cnt++;
        next_cyc();
    endtask

    task automatic test_lock();
        logic [1:0] got;
        idle_all();
        m1_if.cmd_valid = 1;
        m1_if.cmd_addr  = 32'h300;
        m1_if.cmd_read  = 1;
        m0_if.cmd_addr  = 32'h400;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) m0_if.cmd_valid = 1;
            #2;
            total_cnt++;
            if (s_if.cmd_addr !== 32'h300 || s_if.cmd_valid !== 1'b1)
                $display("FAIL lock_hold[%0d]: got addr %h valid %b exp addr %h valid 1", i, s_if.cmd_addr, s_if.cmd_valid, 32'h300);
            else pass_cnt++;
            if (i > 0) begin
                got = {m0_if.cmd_ready, busy};
                total_cnt++;
                if (got !== 2'b01) $display("FAIL lock_m0_blocked[%0d]: got %b exp %b", i, got, 2'b01);
                else pass_cnt++;
            end
            next_cyc();
        end
        s_if.cmd_ready = 1;
        #2;
        got = {m1_if.cmd_ready, m0_if.cmd_ready};
        total_cnt++;
        if (got !== 2'b10 || s_if.cmd_addr !== 32'h300)
            $display("FAIL lock_release: got rdy %b addr %h exp rdy 10 addr %h", got, s_if.cmd_addr, 32'h300);
        else pass_cnt++;
        next_cyc();
        m1_if.cmd_valid = 0;
        #2;
        total_cnt++;
        if (s_if.cmd_addr !== 32'h400 || m0_if.cmd_ready !== 1'b1)
            $display("FAIL lock_m0_after: got addr %h rdy %b exp addr %h rdy 1", s_if.cmd_addr, m0_if.cmd_ready, 32'h400);
        else pass_cnt++;
        next_cyc();
        m0_if.cmd_valid = 0;
    endtask

    task automatic test_rsp_route();
        logic [2:0] got;
        s_if.cmd_ready  = 0;
        s_if.rsp_valid  = 1;
        m1_if.rsp_ready = 0;
        m0_if.rsp_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            got = {s_if.rsp_ready, m0_if.rsp_valid, m1_if.rsp_valid};
            total_cnt++;
            if (got !== 3'b001) $display("FAIL route_stall[%0d]: got %b exp %b", i, got, 3'b001);
            else pass_cnt++;
            next_cyc();
        end
        m1_if.rsp_ready = 1;
        #2;
        got = {s_if.rsp_ready, m0_if.rsp_valid, m1_if.rsp_valid};
        total_cnt++;
        if (got !== 3'b101) $display("FAIL route_m1_done: got %b exp %b", got, 3'b101);
        else pass_cnt++;
        next_cyc();
        #2;
        got = {s_if.rsp_ready, m0_if.rsp_valid, m1_if.rsp_valid};
        total_cnt++;
        if (got !== 3'b110) $display("FAIL route_m0_next: got %b exp %b", got, 3'b110);
        else pass_cnt++;
        next_cyc();
        s_if.rsp_valid = 0;
        #2;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL route_idle_busy: got %b exp 0", busy);
        else pass_cnt++;
        next_cyc();
    endtask

    task automatic test_full();
        logic [2:0] got;
        idle_all();
        s_if.cmd_ready  = 1;
        m0_if.cmd_valid = 1;
        m0_if.cmd_addr  = 32'h500;
        m0_if.rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            total_cnt++;
            if (m0_if.cmd_ready !== 1'b1) $display("FAIL full_accept[%0d]: got %b exp 1", i, m0_if.cmd_ready);
            else pass_cnt++;
            next_cyc();
        end
        #2;
        got = {1'b0, m0_if.cmd_ready, s_if.cmd_valid};
        total_cnt++;
        if (got !== 3'b000) $display("FAIL full_fifth_blocked: got %b exp %b", got, 3'b000);
        else pass_cnt++;
        next_cyc();
        s_if.rsp_valid = 1;
        #2;
        got = {m0_if.cmd_ready, s_if.rsp_ready, m0_if.rsp_valid};
        total_cnt++;
        if (got !== 3'b011) $display("FAIL full_pop_no_push: got %b exp %b", got, 3'b011);
        else pass_cnt++;
        next_cyc();
        s_if.rsp_valid = 0;
        #2;
        got = {1'b0, m0_if.cmd_ready, s_if.cmd_valid};
        total_cnt++;
        if (got !== 3'b011) $display("FAIL full_push_after_pop: got %b exp %b", got, 3'b011);
        else pass_cnt++;
        next_cyc();
        m0_if.cmd_valid = 0;
        s_if.rsp_valid  = 1;
        for (int i = 0; i < 4; i++) next_cyc();
        s_if.rsp_valid = 0;
        #2;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL full_drain_busy: got %b exp 0", busy);
        else pass_cnt++;
        next_cyc();
    endtask

    task automatic test_orphan_reset();
        logic [3:0] got;
        idle_all();
        s_if.rsp_valid = 1;
        #2;
        got = {s_if.rsp_ready, m0_if.rsp_valid, m1_if.rsp_valid, rsp_orphan};
        total_cnt++;
        if (got !== 4'b1000) $display("FAIL orphan_consume: got %b exp %b", got, 4'b1000);
        else pass_cnt++;
        next_cyc();
        s_if.rsp_valid = 0;
        #2;
        total_cnt++;
        if (rsp_orphan !== 1'b1) $display("FAIL orphan_sticky: got %b exp 1", rsp_orphan);
        else pass_cnt++;
        m1_if.cmd_valid = 1;
        next_cyc();
        #2;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL orphan_locked_busy: got %b exp 1", busy);
        else pass_cnt++;
        rst_n = 0;
        #2;
        got = {2'b00, busy, rsp_orphan};
        total_cnt++;
        if (got !== 4'b0000) $display("FAIL async_reset: got %b exp %b", got, 4'b0000);
        else pass_cnt++;
        next_cyc();
        rst_n = 1;
        s_if.cmd_ready  = 1;
        m0_if.cmd_valid = 1;
        m1_if.cmd_valid = 1;
        #2;
        total_cnt++;
        if (s_if.cmd_addr !== 32'h100 || m0_if.cmd_ready !== 1'b1)
            $display("FAIL reset_tie_m0: got addr %h rdy %b exp addr %h rdy 1", s_if.cmd_addr, m0_if.cmd_ready, 32'h100);
        else pass_cnt++;
        next_cyc();
        idle_all();
    endtask

    initial begin
        rst_n = 0;
        idle_all();
        test_reset();
        test_single();
        do_reset();
        test_tie();
        test_lock();
        test_rsp_route();
        test_full();
        test_orphan_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/icb_rr_arb.md
Name: icb_rr_arb

Overview:
- 2-master to 1-slave ICB arbiter with round-robin grant and outstanding-response tracking.
- Lets the core data port and the JTAG debug port share a single ICB slave without the full crossbar; its first use is a dedicated shared-peripheral port.
- Command path is zero-latency pass-through.
- Responses return in order; each is routed to its issuing master by an ID FIFO.

Parameters:
- AW, 32, ICB address width.
- DW, 32, ICB data width; wmask width is DW/8.
- OUTS_DEPTH, 4, maximum outstanding commands; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_icb_cmd_valid/ready  in/out  1  master 0 command handshake
- m0_icb_cmd_addr  in  AW  master 0 address
- m0_icb_cmd_read  in  1  1 = read
- m0_icb_cmd_wdata  in  DW  write data
- m0_icb_cmd_wmask  in  DW/8  byte enables
- m0_icb_rsp_valid/ready  out/in  1  master 0 response handshake
- m0_icb_rsp_err  out  1  response error
- m0_icb_rsp_rdata  out  DW  read data
- m1_icb_* : same set as m0, for master 1
- s_icb_cmd_valid/ready  out/in  1  slave command handshake
- s_icb_cmd_addr/read/wdata/wmask  out  AW/1/DW/DW/8  muxed command payload
- s_icb_rsp_valid/ready  in/out  1  slave response handshake
- s_icb_rsp_err/rdata  in  1/DW  slave response payload
- busy  out  1  grant locked or any response outstanding
- rsp_orphan  out  1  sticky: slave response arrived with nothing outstanding

Behaviour:
- Reset (async):
  - lock=0, lock_id=0, rr_last=1 (m0 wins first tie), FIFO empty, rsp_orphan=0.
  - With master inputs idle, all valid/ready outputs are 0.
- Grant selection, evaluated each cycle:
  - lock=1: sel=lock_id.
  - Otherwise, only one mX_cmd_valid set: sel=that master.
  - Otherwise, both set: sel = master other than rr_last.
  - Otherwise, no request: sel=rr_last (no effect).
- Command path:
  - s_cmd_valid = msel_cmd_valid & ~fifo_full.
  - s_cmd payload = msel payload.
  - msel_cmd_ready = s_cmd_ready & ~fifo_full.
  - Non-selected master's cmd_ready = 0.
- Lock:
  - If s_cmd_valid=1 and s_cmd_ready=0, set lock=1 and lock_id=sel next cycle.
  - The stalled command therefore cannot be preempted; masters must hold valid and payload until ready, per ICB.
  - lock clears on the s_cmd handshake.
  - A master deasserting valid while locked is a protocol violation; the arbiter keeps the lock.
- Round-robin: on each s_cmd handshake, rr_last <= sel.
- ID FIFO:
  - Push sel on s_cmd handshake; pop on s_rsp handshake.
  - fifo_full uses the current count only, so a pop in the same cycle does not free a slot for a push at full.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo OUTS_DEPTH; count is clog2(OUTS_DEPTH)+1 bits.
- Response routing, head = FIFO head ID:
  - mX_rsp_valid = s_rsp_valid & ~empty & (head==X).
  - mX_rsp_err/rdata = s_rsp_* passed through for both masters.
  - s_rsp_ready = mhead_rsp_ready when not empty.
  - A master's rsp_ready is ignored when it is not the head.
- Empty FIFO with s_rsp_valid=1:
  - s_rsp_ready=1 (response discarded), no master sees valid.
  - rsp_orphan <= 1 and stays set until reset.
- busy = lock | ~empty.
- Latency: command 0 cycles added; response 0 cycles added.
- Throughput: 1 command per cycle while the FIFO is not full.

Decomposition:
- Widths come from the shared defines (MemAddrBus, MemBus); no new package types.
- Sub-module icb_id_fifo: synchronous FIFO, 1-bit data, OUTS_DEPTH entries, push/pop/full/empty/head.
- The arbiter top holds the grant, lock and rr logic.

Test Plan:
- Single master: m0 write addr 0x2000_0010, wdata 0xDEADBEEF, wmask 0xF, slave ready=1 -> same-cycle s_cmd with identical payload; m0 rsp_valid on the slave rsp; m1 sees nothing.
- Tie: both masters valid every cycle, slave always ready -> grants alternate m0,m1,m0,m1 starting with m0 after reset; responses land at the matching master in order.
- Lock: m1 valid while slave ready=0 for 3 cycles, m0 asserts valid at cycle 1 -> s_cmd payload stays m1's for all 3 cycles; m0 granted only after the m1 handshake.
- Full: OUTS_DEPTH=4, slave withholds responses -> 4 commands accepted, 5th sees cmd_ready=0. Next cycle, one pop with a valid 5th cmd -> no push that cycle; push accepted the following cycle.
- Routing with backpressure: outstanding IDs m1,m0; m1 rsp_ready=0 for 2 cycles -> s_rsp_ready=0 and m0 rsp_valid=0 until the m1 response completes.
- Orphan and reset: s_rsp_valid with FIFO empty -> rsp_orphan=1 and the response is consumed. Assert rst_n low mid-transaction -> busy=0, rsp_orphan=0, next tie grants m0.
